// File: rtl/mem_access_ctrl.sv
// MAR/MDR memory transaction sequencer: IDLE -> ADDR -> WAIT -> XFER -> DONE.
// Optional WAIT timeout abort enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES    = 2,
    parameter int unsigned CNT_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clock,
    input  logic clear_n,
    input  logic req_rd,
    input  logic req_wr,
    input  logic mem_ready,
    output logic mar_enable,
    output logic mdr_enable,
    output logic mdr_read,
    output logic mem_rd,
    output logic mem_wr,
    output logic busy,
    output logic done,
    output logic err
);

    if ((WAIT_CYCLES >= (2 ** CNT_W)) || (TIMEOUT_CYCLES >= (2 ** CNT_W))) begin : g_bad_cnt_w
        $error("mem_access_ctrl: counter width too small for WAIT_CYCLES/TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_XFER,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LP_WAIT = CNT_W'(WAIT_CYCLES);

    state_t           r_state;
    state_t           w_next;
    logic             r_is_rd;
    logic [CNT_W-1:0] r_wait_cnt;

`ifdef MEM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LP_TO = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_err;
    logic             w_timeout;
`endif

    always_comb begin
        w_next     = r_state;
        mar_enable = 1'b0;
        mdr_enable = 1'b0;
        mdr_read   = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
`ifdef MEM_TIMEOUT_EN
        w_timeout  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (req_rd || req_wr) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                mar_enable = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                mem_rd = r_is_rd;
                // A normal exit takes priority over a timeout on the same edge.
                if ((r_wait_cnt == '0) && mem_ready) begin
                    w_next = S_XFER;
                end
`ifdef MEM_TIMEOUT_EN
                else if (r_to_cnt == LP_TO) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
`endif
            end
            S_XFER: begin
                mem_rd     = r_is_rd;
                mdr_enable = r_is_rd;
                mdr_read   = r_is_rd;
                mem_wr     = ~r_is_rd;
                w_next     = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
`ifdef MEM_TIMEOUT_EN
                err    = r_err;
`endif
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state    <= S_IDLE;
            r_is_rd    <= 1'b0;
            r_wait_cnt <= '0;
`ifdef MEM_TIMEOUT_EN
            r_to_cnt   <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (req_rd || req_wr) begin
                        r_is_rd <= req_rd;
                    end
                end
                S_ADDR: begin
                    r_wait_cnt <= LP_WAIT;
`ifdef MEM_TIMEOUT_EN
                    r_to_cnt   <= '0;
                    r_err      <= 1'b0;
`endif
                end
                S_WAIT: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end
`ifdef MEM_TIMEOUT_EN
                    if (r_to_cnt != LP_TO) begin
                        r_to_cnt <= r_to_cnt + CNT_W'(1);
                    end
                    if (w_timeout) begin
                        r_err <= 1'b1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected transaction
// outcomes, a negedge monitor pops and compares on every done pulse.
module tb_mem_access_ctrl;

    localparam int W  = 2;
    localparam int TO = 15;

    logic clock;
    logic clear_n;
    logic req_rd;
    logic req_wr;
    logic mem_ready;
    logic mar_enable;
    logic mdr_enable;
    logic mdr_read;
    logic mem_rd;
    logic mem_wr;
    logic busy;
    logic done;
    logic err;

    mem_access_ctrl #(
        .WAIT_CYCLES    (W),
        .CNT_W          (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .mem_ready  (mem_ready),
        .mar_enable (mar_enable),
        .mdr_enable (mdr_enable),
        .mdr_read   (mdr_read),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        bit rd;
        int done_cyc;
        bit err;
        int n_mdr;
        int n_wr;
        int n_memrd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en = 0;
    int   n_mar, n_mdr, n_wr, n_memrd;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: per-transaction strobe tallies, resolved against the scoreboard at done.
    initial begin
        n_mar = 0; n_mdr = 0; n_wr = 0; n_memrd = 0;
    end

    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            if (mar_enable) n_mar++;
            if (mdr_enable) n_mdr++;
            if (mem_wr)     n_wr++;
            if (mem_rd)     n_memrd++;
            chk("mdr_read_eq_mdr_enable", int'(mdr_read), int'(mdr_enable));
            if (mar_enable || mem_rd || mem_wr || done) chk("busy_when_active", int'(busy), 1);
            if (!done) chk("err_without_done", int'(err), 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("err_flag", int'(err), int'(e.err));
                    chk("mar_pulses", n_mar, 1);
                    chk("mdr_enable_cycles", n_mdr, e.n_mdr);
                    chk("mem_wr_cycles", n_wr, e.n_wr);
                    chk("mem_rd_cycles", n_memrd, e.n_memrd);
                end
                n_mar = 0; n_mdr = 0; n_wr = 0; n_memrd = 0;
            end
        end
    end

    // One transaction: ready[k] is mem_ready during cycle k after acceptance (ADDR = cycle 1).
    task automatic issue(input bit rd, input bit both, input int r, input bit noise);
        bit   ready [64];
        int   exit_k;
        int   done_rel;
        bit   to;
        bit   got;
        int   acc;
        exp_t e;
        for (int k = 0; k < 64; k++)
            ready[k] = (k >= r) || (noise && ($urandom_range(0, 3) == 0));
        exit_k = 1000;
        for (int k = 2 + W; k < 64; k++) begin
            if (ready[k] && exit_k == 1000) exit_k = k;
        end
        e.rd = rd || both;
        to = 1'b0;
`ifdef MEM_TIMEOUT_EN
        if (exit_k > 2 + TO) to = 1'b1;
`endif
        if (to) begin
            done_rel  = 3 + TO;
            e.err     = 1'b1;
            e.n_mdr   = 0;
            e.n_wr    = 0;
            e.n_memrd = e.rd ? TO + 1 : 0;
        end else begin
            done_rel  = exit_k + 2;
            e.err     = 1'b0;
            e.n_mdr   = e.rd ? 1 : 0;
            e.n_wr    = e.rd ? 0 : 1;
            e.n_memrd = e.rd ? exit_k : 0;
        end
        @(posedge clock); #1;
        req_rd    = e.rd;
        req_wr    = !e.rd || both;
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
        acc = cyc;
        e.done_cyc = acc + done_rel - 1;
        exp_q.push_back(e);
        got = 1'b0;
        for (int k = 1; k <= 80 && !got; k++) begin
            mem_ready = (k < 64) ? ready[k] : 1'b1;
            req_rd = noise && (k >= 2) && ($urandom_range(0, 2) == 0);
            req_wr = noise && (k >= 2) && ($urandom_range(0, 2) == 0);
            @(negedge clock);
            if (done) got = 1'b1;
            else begin
                @(posedge clock); #1;
            end
        end
        if (!got) chk("txn_hang", 0, 1);
        req_rd = 1'b0;
        req_wr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_n   = 1'b0;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        mem_ready = 1'b0;
        #23;
        chk("reset_outputs", int'({mar_enable, mdr_enable, mdr_read, mem_rd, mem_wr, busy, done, err}), 0);
        @(negedge clock);
        clear_n = 1'b1;

        // Asynchronous reset during a write's WAIT must abort with no write strobe.
        @(posedge clock); #1;
        req_wr = 1'b1;
        @(posedge clock); #1;
        req_wr = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("mid_wait_busy", int'(busy), 1);
        #2;
        clear_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({mar_enable, mdr_enable, mdr_read, mem_rd, mem_wr, busy, done, err}), 0);
        mem_ready = 1'b1;
        @(posedge clock); #1;
        chk("reset_held_busy", int'(busy), 0);
        clear_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("post_reset_quiet", int'({mem_wr, mdr_enable, done, busy}), 0);
        end

        mon_en = 1'b1;
        issue(1'b1, 1'b0, 0, 1'b0);   // read, fast memory
        issue(1'b0, 1'b0, 0, 1'b0);   // write, fast memory
        issue(1'b1, 1'b0, 8, 1'b0);   // read, slow memory
        issue(1'b0, 1'b0, 8, 1'b0);   // write, slow memory
        issue(1'b0, 1'b1, 0, 1'b1);   // both requests: read wins, extra requests ignored
`ifdef MEM_TIMEOUT_EN
        issue(1'b0, 1'b0, 100, 1'b0); // write timeout
        issue(1'b1, 1'b0, 100, 1'b0); // read timeout
        issue(1'b1, 1'b0, 0, 1'b0);   // recovery read
        issue(1'b1, 1'b0, 2 + TO, 1'b0); // exit on the timeout edge
`endif
        for (int i = 0; i < 30; i++) begin
`ifdef MEM_TIMEOUT_EN
            issue(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom_range(0, 22), 1'b1);
`else
            issue(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom_range(0, 12), 1'b1);
`endif
        end
        repeat (4) @(negedge clock);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("idle_at_end", int'(busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
